// File: rtl/cpu_sequencer.sv
// Multi-cycle control sequencer: owns the PC and steps each instruction through FETCH/DECODE/EXEC/MEM/WB.
// Optional `retired` instruction counter is compiled in when INSTR_CNT_EN is defined.
module cpu_sequencer #(
  parameter int              PC_W        = 16,
  parameter logic [PC_W-1:0] RESET_PC    = '0,
  parameter int              MEM_TIMEOUT = 255
) (
  input  logic            clk,
  input  logic            rst_n,
  output logic [PC_W-1:0] pc,
  input  logic [3:0]      opcode,
  input  logic [1:0]      format,
  input  logic            alu_eq,
  input  logic            alu_lt,
  input  logic [PC_W-1:0] target,
  output logic [3:0]      alu_op,
  output logic            rf_we,
  output logic            mem_req,
  output logic            mem_we,
  input  logic            mem_ready,
  output logic            halted,
  output logic            fault
`ifdef INSTR_CNT_EN
  ,
  output logic [31:0]     retired
`endif
);

  localparam logic [3:0] OP_LB   = 4'b0000;
  localparam logic [3:0] OP_LHB  = 4'b0001;
  localparam logic [3:0] OP_JMP  = 4'b0010;
  localparam logic [3:0] OP_STR  = 4'b0011;
  localparam logic [3:0] OP_BNE  = 4'b1010;
  localparam logic [3:0] OP_BEQ  = 4'b1011;
  localparam logic [3:0] OP_BLT  = 4'b1100;
  localparam logic [3:0] OP_HALT = 4'b1110;
  localparam logic [3:0] OP_TBA  = 4'b1111;

  // Last MEM cycle index before the request is abandoned.
  localparam logic [7:0] TMO_LAST = 8'(MEM_TIMEOUT - 1);

  typedef enum logic [2:0] {
    FETCH  = 3'd0,
    DECODE = 3'd1,
    EXEC   = 3'd2,
    MEM    = 3'd3,
    WB     = 3'd4,
    HALT   = 3'd5
  } state_t;

  state_t          state, state_next;
  logic [PC_W-1:0] pc_d, pc_inc;
  logic [3:0]      alu_op_d;
  logic            rf_we_d, mem_req_d, mem_we_d, halted_d, fault_d;
  logic [7:0]      tmo_cnt, tmo_d;
  logic            op_is_mem, op_is_store, op_is_flow;
  logic            mem_done, tmo_hit;
  logic            unused_format;

  // The decoder's format field carries no sequencing information here.
  assign unused_format = ^format;

  assign pc_inc      = pc + {{(PC_W-1){1'b0}}, 1'b1};
  assign op_is_mem   = alu_op inside {OP_LB, OP_LHB, OP_STR};
  assign op_is_store = (alu_op == OP_STR);
  assign op_is_flow  = alu_op inside {OP_JMP, OP_BEQ, OP_BNE, OP_BLT};
  assign mem_done    = mem_req & mem_ready;
  assign tmo_hit     = (tmo_cnt == TMO_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state   <= FETCH;
      pc      <= RESET_PC;
      alu_op  <= 4'd0;
      rf_we   <= 1'b0;
      mem_req <= 1'b0;
      mem_we  <= 1'b0;
      halted  <= 1'b0;
      fault   <= 1'b0;
      tmo_cnt <= 8'd0;
    end else begin
      state   <= state_next;
      pc      <= pc_d;
      alu_op  <= alu_op_d;
      rf_we   <= rf_we_d;
      mem_req <= mem_req_d;
      mem_we  <= mem_we_d;
      halted  <= halted_d;
      fault   <= fault_d;
      tmo_cnt <= tmo_d;
    end
  end

  always_comb begin
    state_next = state;
    case (state)
      FETCH:  state_next = DECODE;
      DECODE: begin
        if (opcode == OP_HALT)     state_next = HALT;
        else if (opcode == OP_TBA) state_next = FETCH;
        else                       state_next = EXEC;
      end
      EXEC: begin
        if (op_is_mem)       state_next = MEM;
        else if (op_is_flow) state_next = FETCH;
        else                 state_next = WB;
      end
      MEM: begin
        if (mem_done)     state_next = op_is_store ? FETCH : WB;
        else if (tmo_hit) state_next = FETCH;
      end
      WB:      state_next = FETCH;
      HALT:    state_next = HALT;
      default: state_next = FETCH;
    endcase
  end

  // Next values for the registered outputs; strobes default low every cycle.
  always_comb begin
    pc_d      = pc;
    alu_op_d  = alu_op;
    rf_we_d   = 1'b0;
    mem_req_d = 1'b0;
    mem_we_d  = 1'b0;
    halted_d  = halted;
    fault_d   = fault;
    tmo_d     = tmo_cnt;
    case (state)
      DECODE: begin
        alu_op_d = opcode;
        if (opcode == OP_HALT)     halted_d = 1'b1;
        else if (opcode == OP_TBA) pc_d = pc_inc;
      end
      EXEC: begin
        tmo_d = 8'd0;
        case (alu_op)
          OP_JMP: pc_d = target;
          OP_BEQ: pc_d = alu_eq  ? target : pc_inc;
          OP_BNE: pc_d = !alu_eq ? target : pc_inc;
          OP_BLT: pc_d = alu_lt  ? target : pc_inc;
          OP_LB, OP_LHB: mem_req_d = 1'b1;
          OP_STR: begin
            mem_req_d = 1'b1;
            mem_we_d  = 1'b1;
          end
          default: rf_we_d = 1'b1;
        endcase
      end
      MEM: begin
        if (mem_done) begin
          if (op_is_store) pc_d = pc_inc;
          else             rf_we_d = 1'b1;
        end else if (tmo_hit) begin
          fault_d = 1'b1;
          pc_d    = pc_inc;
        end else begin
          mem_req_d = 1'b1;
          mem_we_d  = mem_we;
          tmo_d     = tmo_cnt + 8'd1;
        end
      end
      WB:      pc_d = pc_inc;
      HALT:    halted_d = 1'b1;
      default: ;
    endcase
  end

`ifdef INSTR_CNT_EN
  // Every return to FETCH from a running instruction retires it.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      retired <= 32'd0;
    else if (state_next == FETCH && state != FETCH)
      retired <= retired + 32'd1;
  end
`endif

endmodule

// File: tb/tb_cpu_sequencer.sv
// Directed bench for cpu_sequencer: a 256-entry opcode ROM indexed by pc[7:0] and a hand-driven memory port.
module tb_cpu_sequencer;

  logic        clk;
  logic        rst_n;
  logic [15:0] pc;
  logic [3:0]  opcode;
  logic [1:0]  format;
  logic        alu_eq;
  logic        alu_lt;
  logic [15:0] target;
  logic [3:0]  alu_op;
  logic        rf_we;
  logic        mem_req;
  logic        mem_we;
  logic        mem_ready;
  logic        halted;
  logic        fault;
`ifdef INSTR_CNT_EN
  logic [31:0] retired;
`endif

  logic [3:0] rom [256];
  int checks = 0;
  int errors = 0;
  int cnt;

  cpu_sequencer #(.PC_W(16), .RESET_PC(16'h0000), .MEM_TIMEOUT(255)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .pc        (pc),
    .opcode    (opcode),
    .format    (format),
    .alu_eq    (alu_eq),
    .alu_lt    (alu_lt),
    .target    (target),
    .alu_op    (alu_op),
    .rf_we     (rf_we),
    .mem_req   (mem_req),
    .mem_we    (mem_we),
    .mem_ready (mem_ready),
    .halted    (halted),
    .fault     (fault)
`ifdef INSTR_CNT_EN
    ,
    .retired   (retired)
`endif
  );

  assign opcode = rom[pc[7:0]];
  assign format = 2'b00;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
    end
  endtask

  task automatic applyStimulus(input logic eq, input logic lt, input logic [15:0] tgt);
    alu_eq = eq;
    alu_lt = lt;
    target = tgt;
  endtask

  // Advance n rising edges and settle 1 time unit past the last one.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 256; i++) rom[i] = 4'b0111;
    rom[8'h00] = 4'b0111;
    rom[8'h01] = 4'b1011;
    rom[8'h02] = 4'b1111;
    rom[8'h03] = 4'b1110;
    rom[8'h40] = 4'b1010;
    rom[8'h41] = 4'b1100;
    rom[8'h80] = 4'b0000;
    rom[8'h81] = 4'b0011;
    rom[8'h82] = 4'b0000;
    rom[8'h83] = 4'b0111;
    rom[8'h84] = 4'b0010;
    rom[8'hFF] = 4'b0111;

    rst_n     = 1'b0;
    mem_ready = 1'b0;
    applyStimulus(1'b0, 1'b0, 16'h0000);
    #2;
    checkOutput("reset_pc", 32'(pc), 32'h0);
    checkOutput("reset_alu_op", 32'(alu_op), 32'h0);
    checkOutput("reset_strobes", {29'd0, rf_we, mem_req, mem_we}, 32'h0);
    checkOutput("reset_flags", {30'd0, halted, fault}, 32'h0);
`ifdef INSTR_CNT_EN
    checkOutput("reset_retired", retired, 32'd0);
`endif
    tick(1);
    rst_n = 1'b1;

    $display("[TB] ADD at pc 0");
    tick(2);
    checkOutput("add_alu_op", 32'(alu_op), 32'h7);
    checkOutput("add_exec_no_we", 32'(rf_we), 32'h0);
    tick(1);
    checkOutput("add_wb_we", 32'(rf_we), 32'h1);
    checkOutput("add_wb_pc", 32'(pc), 32'h0);
    tick(1);
    checkOutput("add_pc", 32'(pc), 32'h1);
    checkOutput("add_we_drop", 32'(rf_we), 32'h0);

    $display("[TB] branches");
    applyStimulus(1'b1, 1'b0, 16'h0040);
    tick(2);
    checkOutput("beq_exec_no_we", 32'(rf_we), 32'h0);
    tick(1);
    checkOutput("beq_taken_pc", 32'(pc), 32'h40);
    checkOutput("beq_no_we", 32'(rf_we), 32'h0);
    applyStimulus(1'b1, 1'b0, 16'h1234);
    tick(3);
    checkOutput("bne_not_taken_pc", 32'(pc), 32'h41);
    applyStimulus(1'b0, 1'b1, 16'h0080);
    tick(3);
    checkOutput("blt_taken_pc", 32'(pc), 32'h80);

    $display("[TB] LB with delayed ready");
    applyStimulus(1'b0, 1'b0, 16'h0000);
    tick(3);
    for (int i = 0; i < 5; i++) begin
      checkOutput("lb_req_held", {30'd0, mem_req, mem_we}, 32'h2);
      if (i == 4) mem_ready = 1'b1;
      tick(1);
    end
    mem_ready = 1'b0;
    checkOutput("lb_req_drop", 32'(mem_req), 32'h0);
    checkOutput("lb_wb_we", 32'(rf_we), 32'h1);
    tick(1);
    checkOutput("lb_pc", 32'(pc), 32'h81);
    checkOutput("lb_we_drop", 32'(rf_we), 32'h0);

    $display("[TB] STR with immediate ready");
    mem_ready = 1'b1;
    tick(3);
    checkOutput("str_req", {29'd0, mem_req, mem_we, rf_we}, 32'h6);
    tick(1);
    checkOutput("str_done", {29'd0, mem_req, mem_we, rf_we}, 32'h0);
    checkOutput("str_pc", 32'(pc), 32'h82);
    mem_ready = 1'b0;

    $display("[TB] LB timeout");
    tick(3);
    cnt = 0;
    while (mem_req === 1'b1 && cnt < 400) begin
      cnt++;
      tick(1);
    end
    checkOutput("tmo_req_cycles", 32'(cnt), 32'd255);
    checkOutput("tmo_fault", 32'(fault), 32'h1);
    checkOutput("tmo_pc", 32'(pc), 32'h83);
    checkOutput("tmo_no_we", 32'(rf_we), 32'h0);
    tick(4);
    checkOutput("fault_sticky", 32'(fault), 32'h1);
    checkOutput("after_tmo_pc", 32'(pc), 32'h84);

    $display("[TB] JMP and pc wrap");
    applyStimulus(1'b0, 1'b0, 16'hFFFF);
    tick(3);
    checkOutput("jmp_pc", 32'(pc), 32'hFFFF);
    tick(4);
    checkOutput("wrap_pc", 32'(pc), 32'h0);
    tick(4);
    checkOutput("add2_pc", 32'(pc), 32'h1);
    applyStimulus(1'b0, 1'b0, 16'h0040);
    tick(3);
    checkOutput("beq_not_taken_pc", 32'(pc), 32'h2);
    tick(2);
    checkOutput("nop_pc", 32'(pc), 32'h3);

    $display("[TB] HALT");
    tick(2);
    checkOutput("halt_flag", 32'(halted), 32'h1);
    checkOutput("halt_alu_op", 32'(alu_op), 32'hE);
`ifdef INSTR_CNT_EN
    checkOutput("retired_count", retired, 32'd13);
`endif
    for (int i = 0; i < 10; i++) begin
      tick(10);
      checkOutput("halt_pc_frozen", 32'(pc), 32'h3);
    end
    checkOutput("halt_strobes", {29'd0, rf_we, mem_req, mem_we}, 32'h0);
    checkOutput("halt_still", 32'(halted), 32'h1);

    $display("[TB] reset during HALT");
    rom[8'h00] = 4'b0000;
    #3;
    rst_n = 1'b0;
    #2;
    checkOutput("rst_halt_pc", 32'(pc), 32'h0);
    checkOutput("rst_halt_flags", {30'd0, halted, fault}, 32'h0);
`ifdef INSTR_CNT_EN
    checkOutput("rst_retired", retired, 32'd0);
`endif
    tick(1);
    rst_n = 1'b1;

    $display("[TB] reset during MEM");
    tick(3);
    checkOutput("pre_rst_req", 32'(mem_req), 32'h1);
    tick(2);
    #3;
    rst_n = 1'b0;
    #2;
    checkOutput("rst_mem_req", 32'(mem_req), 32'h0);
    checkOutput("rst_mem_pc", 32'(pc), 32'h0);
    tick(1);
    rst_n = 1'b1;
    tick(3);
    checkOutput("restart_req", {29'd0, mem_req, mem_we, rf_we}, 32'h4);
    checkOutput("restart_pc", 32'(pc), 32'h0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
